// File: rtl/cmp_pkg.sv
// Shared state encoding and width helper for the iterative magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational W-bit unsigned comparator slice producing greater-than and equal.
module cmp_chunk #(
    parameter int W = 2
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_gt,
    output logic         o_eq
);

    assign o_gt = (i_a > i_b);
    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/iter_mag_cmp.sv
// Iterative magnitude comparator: walks CHUNK-bit slices MSB first and stops at the
// first differing slice; signed mode flips the sign bit on the MSB slice (offset binary).
module iter_mag_cmp
    import cmp_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int CHUNK  = 2,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW     = clog2(NCHUNK) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             agtb,
    output logic             aeqb,
    output logic             altb,
    output logic             ageb,
    output logic [CW-1:0]    cycles
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_sgn;
    logic [CW-1:0]     r_idx;
    logic              r_agtb;
    logic              r_aeqb;
    logic              r_altb;
    logic              r_ageb;
    logic [CW-1:0]     r_cycles;

    logic              w_load;
    logic              w_fin;
    logic              w_last;
    logic [WIDTH-1:0]  w_flip;
    logic [WIDTH-1:0]  w_a_sh;
    logic [WIDTH-1:0]  w_b_sh;
    logic [31:0]       w_shamt;
    logic [CHUNK-1:0]  w_a_chk;
    logic [CHUNK-1:0]  w_b_chk;
    logic              w_gt;
    logic              w_eq;

    // Sign bit lives only in chunk 0, so the flip is applied just there.
    assign w_flip  = (r_sgn && (r_idx == '0)) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
    assign w_shamt = 32'(r_idx) * 32'(CHUNK);
    assign w_a_sh  = (r_a ^ w_flip) << w_shamt;
    assign w_b_sh  = (r_b ^ w_flip) << w_shamt;
    assign w_a_chk = w_a_sh[WIDTH-1 -: CHUNK];
    assign w_b_chk = w_b_sh[WIDTH-1 -: CHUNK];
    assign w_last  = (r_idx == CW'(NCHUNK - 1));

    cmp_chunk #(.W(CHUNK)) u_chunk (
        .i_a  (w_a_chk),
        .i_b  (w_b_chk),
        .o_gt (w_gt),
        .o_eq (w_eq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!w_eq || w_last) begin
                    w_fin       = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sgn    <= 1'b0;
            r_idx    <= '0;
            r_agtb   <= 1'b0;
            r_aeqb   <= 1'b0;
            r_altb   <= 1'b0;
            r_ageb   <= 1'b0;
            r_cycles <= '0;
        end else begin
            if (w_load) begin
                r_a   <= a;
                r_b   <= b;
                r_sgn <= sgn;
                r_idx <= '0;
            end else if ((r_state == RUN) && !w_fin) begin
                r_idx <= r_idx + CW'(1);
            end
            // On the final equal slice w_eq=1 and w_gt=0, giving the equal result.
            if (w_fin) begin
                r_agtb   <= w_gt;
                r_aeqb   <= w_eq;
                r_altb   <= !w_gt && !w_eq;
                r_ageb   <= w_gt || w_eq;
                r_cycles <= r_idx + CW'(1);
            end
        end
    end

    assign ready  = (r_state == IDLE);
    assign done   = (r_state == DONE);
    assign agtb   = r_agtb;
    assign aeqb   = r_aeqb;
    assign altb   = r_altb;
    assign ageb   = r_ageb;
    assign cycles = r_cycles;

endmodule

// File: tb/tb_iter_mag_cmp.sv
// Bench for iter_mag_cmp: directed 8-bit/2-bit scenarios and randomized 32-bit/4-bit runs.
module tb_iter_mag_cmp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic       s8_start, s8_sgn;
    logic [7:0] s8_a, s8_b;
    logic       d8_ready, d8_done, d8_agtb, d8_aeqb, d8_altb, d8_ageb;
    logic [2:0] d8_cycles;

    logic        s32_start, s32_sgn;
    logic [31:0] s32_a, s32_b;
    logic        d32_ready, d32_done, d32_agtb, d32_aeqb, d32_altb, d32_ageb;
    logic [3:0]  d32_cycles;

    iter_mag_cmp #(.WIDTH(8), .CHUNK(2)) u_dut8 (
        .clk(clk), .reset(reset), .start(s8_start), .sgn(s8_sgn), .a(s8_a), .b(s8_b),
        .ready(d8_ready), .done(d8_done), .agtb(d8_agtb), .aeqb(d8_aeqb),
        .altb(d8_altb), .ageb(d8_ageb), .cycles(d8_cycles)
    );

    iter_mag_cmp #(.WIDTH(32), .CHUNK(4)) u_dut32 (
        .clk(clk), .reset(reset), .start(s32_start), .sgn(s32_sgn), .a(s32_a), .b(s32_b),
        .ready(d32_ready), .done(d32_done), .agtb(d32_agtb), .aeqb(d32_aeqb),
        .altb(d32_altb), .ageb(d32_ageb), .cycles(d32_cycles)
    );

    // Reference: numeric compare of the operand values plus first differing chunk index.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  input int w, input int c,
                                  output logic gt, output logic eq, output logic lt,
                                  output int cyc);
        longint va, vb, mask;
        int     n;
        logic   found;
        va = longint'(a);
        vb = longint'(b);
        if (s && a[w-1]) va = va - (longint'(1) << w);
        if (s && b[w-1]) vb = vb - (longint'(1) << w);
        gt = (va > vb);
        eq = (va == vb);
        lt = (va < vb);
        n = w / c;
        mask = (longint'(1) << c) - 1;
        cyc = n;
        found = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (!found && (((longint'(a) >> ((n-1-k)*c)) & mask) != ((longint'(b) >> ((n-1-k)*c)) & mask))) begin
                cyc = k + 1;
                found = 1'b1;
            end
        end
    endfunction

    // Drives one compare on the 8-bit instance; returns at the negedge where done is seen.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
        @(negedge clk);
        s8_a = a; s8_b = b; s8_sgn = s; s8_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s8_start = 1'b0; s8_a = ~a; s8_b = ~b; s8_sgn = ~s;
        lat = 1;
        while (!d8_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!d8_done) lat = -1;
    endtask

    task automatic test_reset;
        n_tests++;
        if ({d8_ready, d8_done, d8_agtb, d8_aeqb, d8_altb, d8_ageb, d8_cycles} !== {6'b100000, 3'd0}) begin
            n_fail++;
            $display("FAIL reset8: got rdy=%b done=%b gt=%b eq=%b lt=%b ge=%b cyc=%0d, want 1 0 0 0 0 0 0",
                     d8_ready, d8_done, d8_agtb, d8_aeqb, d8_altb, d8_ageb, d8_cycles);
        end
        n_tests++;
        if ({d32_ready, d32_done, d32_agtb, d32_aeqb, d32_altb, d32_ageb, d32_cycles} !== {6'b100000, 4'd0}) begin
            n_fail++;
            $display("FAIL reset32: got rdy=%b done=%b flags=%b%b%b%b cyc=%0d, want 1 0 0000 0",
                     d32_ready, d32_done, d32_agtb, d32_aeqb, d32_altb, d32_ageb, d32_cycles);
        end
    endtask

    task automatic test_basic;
        int lat;
        run8(8'hC5, 8'h3A, 1'b0, lat);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL msb_lat: got %0d want 2", lat); end
        n_tests++;
        if ({d8_agtb, d8_aeqb, d8_altb, d8_ageb} !== 4'b1001 || d8_cycles !== 3'd1) begin
            n_fail++;
            $display("FAIL msb_res: got gt/eq/lt/ge=%b%b%b%b cyc=%0d want 1001 cyc=1",
                     d8_agtb, d8_aeqb, d8_altb, d8_ageb, d8_cycles);
        end
        @(negedge clk);
        n_tests++;
        if (d8_done !== 1'b0 || d8_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b ready=%b want 0 1", d8_done, d8_ready);
        end
        run8(8'h5A, 8'h5A, 1'b0, lat);
        n_tests++;
        if (lat !== 5) begin n_fail++; $display("FAIL eq_lat: got %0d want 5", lat); end
        n_tests++;
        if ({d8_agtb, d8_aeqb, d8_altb, d8_ageb} !== 4'b0101 || d8_cycles !== 3'd4) begin
            n_fail++;
            $display("FAIL eq_res: got %b%b%b%b cyc=%0d want 0101 cyc=4",
                     d8_agtb, d8_aeqb, d8_altb, d8_ageb, d8_cycles);
        end
    endtask

    task automatic test_signed;
        int lat;
        run8(8'h80, 8'h01, 1'b1, lat);
        n_tests++;
        if ({d8_agtb, d8_aeqb, d8_altb, d8_ageb} !== 4'b0010 || d8_cycles !== 3'd1 || lat !== 2) begin
            n_fail++;
            $display("FAIL signed_neg: got %b%b%b%b cyc=%0d lat=%0d want 0010 cyc=1 lat=2",
                     d8_agtb, d8_aeqb, d8_altb, d8_ageb, d8_cycles, lat);
        end
        run8(8'h80, 8'h01, 1'b0, lat);
        n_tests++;
        if ({d8_agtb, d8_aeqb, d8_altb, d8_ageb} !== 4'b1001 || d8_cycles !== 3'd1) begin
            n_fail++;
            $display("FAIL unsigned_80: got %b%b%b%b cyc=%0d want 1001 cyc=1",
                     d8_agtb, d8_aeqb, d8_altb, d8_ageb, d8_cycles);
        end
    endtask

    task automatic test_last_chunk;
        int lat;
        run8(8'h57, 8'h56, 1'b0, lat);
        n_tests++;
        if (lat !== 5 || {d8_agtb, d8_aeqb, d8_altb, d8_ageb} !== 4'b1001 || d8_cycles !== 3'd4) begin
            n_fail++;
            $display("FAIL last_gt: got %b%b%b%b cyc=%0d lat=%0d want 1001 cyc=4 lat=5",
                     d8_agtb, d8_aeqb, d8_altb, d8_ageb, d8_cycles, lat);
        end
        run8(8'h56, 8'h57, 1'b0, lat);
        n_tests++;
        if ({d8_agtb, d8_aeqb, d8_altb, d8_ageb} !== 4'b0010 || d8_cycles !== 3'd4) begin
            n_fail++;
            $display("FAIL last_lt: got %b%b%b%b cyc=%0d want 0010 cyc=4",
                     d8_agtb, d8_aeqb, d8_altb, d8_ageb, d8_cycles);
        end
    endtask

    task automatic test_ignore_and_reset;
        int ndone = 0;
        int late  = 0;
        @(negedge clk);
        s8_a = 8'h5A; s8_b = 8'h5B; s8_sgn = 1'b0; s8_start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (d8_done) ndone++;
            s8_start = (i == 2);
            if (i == 2) begin s8_a = 8'h00; s8_b = 8'hFF; end
        end
        n_tests++;
        if (ndone !== 1) begin n_fail++; $display("FAIL ignore_cnt: got %0d dones want 1", ndone); end
        n_tests++;
        if ({d8_agtb, d8_aeqb, d8_altb, d8_ageb} !== 4'b0010 || d8_cycles !== 3'd4) begin
            n_fail++;
            $display("FAIL ignore_res: got %b%b%b%b cyc=%0d want 0010 cyc=4",
                     d8_agtb, d8_aeqb, d8_altb, d8_ageb, d8_cycles);
        end
        @(negedge clk);
        s8_a = 8'h5A; s8_b = 8'h5A; s8_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s8_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({d8_ready, d8_done, d8_agtb, d8_aeqb, d8_altb, d8_ageb, d8_cycles} !== {6'b100000, 3'd0}) begin
            n_fail++;
            $display("FAIL midrun_reset: got rdy=%b done=%b flags=%b%b%b%b cyc=%0d want 1 0 0000 0",
                     d8_ready, d8_done, d8_agtb, d8_aeqb, d8_altb, d8_ageb, d8_cycles);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (d8_done) late++;
        end
        n_tests++;
        if (late !== 0) begin n_fail++; $display("FAIL dropped_done: got %0d dones want 0", late); end
    endtask

    task automatic test_back_to_back;
        int   issued = 0, got = 0, t0 = 0, ecyc = 0;
        logic prev = 1'b0, egt = 1'b0, eeq = 1'b0, elt = 1'b0;
        logic [31:0] ra, rb;
        logic        rs;
        for (int i = 0; i < 6000 && got < 200; i++) begin
            @(negedge clk);
            if (d32_done) begin
                got++;
                n_tests++;
                if ({d32_agtb, d32_aeqb, d32_altb, d32_ageb} !== {egt, eeq, elt, egt | eeq}) begin
                    n_fail++;
                    $display("FAIL rand_res #%0d a=%h b=%h s=%b: got %b%b%b%b want %b%b%b%b", got, ra, rb, rs,
                             d32_agtb, d32_aeqb, d32_altb, d32_ageb, egt, eeq, elt, egt | eeq);
                end
                n_tests++;
                if (int'(d32_cycles) !== ecyc || (i - t0) !== ecyc + 1) begin
                    n_fail++;
                    $display("FAIL rand_cyc #%0d a=%h b=%h: got cyc=%0d lat=%0d want cyc=%0d lat=%0d",
                             got, ra, rb, d32_cycles, i - t0, ecyc, ecyc + 1);
                end
                n_tests++;
                if (prev) begin n_fail++; $display("FAIL done_twice: got consecutive done want single"); end
            end
            prev = d32_done;
            if (d32_ready && issued < 200) begin
                ra = $urandom;
                case ($urandom_range(0, 3))
                    0: rb = $urandom;
                    1: rb = ra;
                    2: rb = ra ^ (32'h1 << $urandom_range(0, 31));
                    default: rb = ra ^ (32'($urandom) & 32'h0000_0FFF);
                endcase
                rs = 1'($urandom_range(0, 1));
                model(ra, rb, rs, 32, 4, egt, eeq, elt, ecyc);
                s32_a = ra; s32_b = rb; s32_sgn = rs; s32_start = 1'b1;
                issued++;
                t0 = i;
            end else begin
                s32_start = 1'b0;
                s32_a = $urandom; s32_b = $urandom; s32_sgn = 1'($urandom_range(0, 1));
            end
        end
        n_tests++;
        if (got !== 200) begin n_fail++; $display("FAIL rand_count: got %0d results want 200", got); end
    endtask

    initial begin
        reset = 1'b1;
        s8_start = 1'b0;  s8_sgn = 1'b0;  s8_a = '0;  s8_b = '0;
        s32_start = 1'b0; s32_sgn = 1'b0; s32_a = '0; s32_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset;
        test_basic;
        test_signed;
        test_last_chunk;
        test_ignore_and_reset;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
